// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequencer/arbiter for the unified instruction/data memory.
// Grants the single memory port to the fetch or load/store requester, drives
// WE/A/WD, captures RD, and performs read-modify-write for byte/half stores
// (the memory only writes whole big-endian 32-bit words).
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   f_req/f_addr/f_ack            fetch request, byte address, accept pulse
//   d_req/d_we/d_size/d_addr/
//   d_wdata/d_ack                 load/store request fields, accept pulse
//   rsp_valid/rsp_id/rsp_rdata/
//   rsp_err                       one-cycle response (id 0 fetch, 1 data)
//   mem_we/mem_a/mem_wd/mem_rd    memory port
//   busy                          high whenever the sequencer is not idle
//
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// data has fixed priority over fetch.
module mem_port_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         f_req,
  input  logic [N-1:0] f_addr,
  output logic         f_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [1:0]   d_size,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic         d_ack,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_we,
  output logic [N-1:0] mem_a,
  output logic [N-1:0] mem_wd,
  input  logic [N-1:0] mem_rd,
  output logic         busy
);

  localparam int unsigned SHW = $clog2(N);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_e;

  state_e         state_q, state_d;
  logic           id_q, we_q, err_q;
  logic [1:0]     size_q;
  logic [N-1:0]   addr_q, wdata_q, rdata_q;
  logic           accept_c, sel_d_c, err_c, d_pri_c;
  logic [SHW-1:0] lane_sh_c;
  logic [N-1:0]   lane_mask_c, lane_data_c, merged_c;

`ifdef MEM_ARB_RR_EN
  // last_q: 1 = data granted last, 0 = fetch granted last
  logic last_q;
  assign d_pri_c = ~last_q;
`else
  assign d_pri_c = 1'b1;
`endif

  // Arbitration and acceptance-time legality check
  always_comb begin
    accept_c = (state_q == S_IDLE) && !RST && (f_req || d_req);
    sel_d_c  = d_req && (!f_req || d_pri_c);
    err_c    = 1'b0;
    if (sel_d_c) begin
      case (d_size)
        SZ_BYTE: err_c = 1'b0;
        SZ_HALF: err_c = d_addr[0];
        SZ_WORD: err_c = |d_addr[1:0];
        default: err_c = 1'b1;
      endcase
    end else begin
      err_c = |f_addr[1:0];
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = err_c ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = (we_q && size_q != SZ_WORD) ? S_MERGE : S_RESP;
      S_MERGE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, read capture and arbitration pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      if (accept_c) begin
        id_q    <= sel_d_c;
        we_q    <= sel_d_c & d_we;
        err_q   <= err_c;
        size_q  <= sel_d_c ? d_size : SZ_WORD;
        addr_q  <= sel_d_c ? d_addr : f_addr;
        wdata_q <= sel_d_c ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
        last_q  <= sel_d_c;
`endif
      end
      if (state_q == S_ACCESS) rdata_q <= mem_rd;
    end
  end

  // Big-endian lane merge: offset 0 is the most significant byte
  always_comb begin
    if (size_q == SZ_BYTE) begin
      lane_sh_c   = SHW'(N - 8 - 8 * 32'(addr_q[1:0]));
      lane_mask_c = N'(8'hFF) << lane_sh_c;
      lane_data_c = N'(wdata_q[7:0]) << lane_sh_c;
    end else begin
      lane_sh_c   = SHW'(N - 16 - 8 * 32'(addr_q[1:0]));
      lane_mask_c = N'(16'hFFFF) << lane_sh_c;
      lane_data_c = N'(wdata_q[15:0]) << lane_sh_c;
    end
    merged_c = (rdata_q & ~lane_mask_c) | lane_data_c;
  end

  // Outputs decoded from state; acks are combinational on the requests
  always_comb begin
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        f_ack = accept_c & ~sel_d_c;
        d_ack = accept_c & sel_d_c;
      end
      S_ACCESS: begin
        mem_a = {addr_q[N-1:2], 2'b00};
        if (we_q && size_q == SZ_WORD) begin
          mem_we = 1'b1;
          mem_wd = wdata_q;
        end
      end
      S_MERGE: begin
        mem_a  = {addr_q[N-1:2], 2'b00};
        mem_we = 1'b1;
        mem_wd = merged_c;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_err   = err_q;
        rsp_rdata = (we_q || err_q) ? '0 : rdata_q;
      end
      default: ;
    endcase
    // No memory write may happen in a reset cycle
    if (RST) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        f_ack, d_ack, rsp_valid, rsp_id, rsp_err, mem_we, busy;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [64];
  int          checks = 0;
  int          errors = 0;

  mem_port_arbiter #(.N(32)) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Memory model: write on rising edge, RD updates on falling edge
  always @(posedge CLK) if (mem_we === 1'b1) mem[mem_a[7:2]] <= mem_wd;
  always @(negedge CLK) mem_rd <= mem[mem_a[7:2]];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0; f_addr = 32'h0;
    #1;
    checks++; if (f_ack !== 1'b0) begin errors++; $display("FAIL rst_f_ack: got %0h exp 0", f_ack); end
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL rst_d_ack: got %0h exp 0", d_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h exp 0", busy); end
    step(); #1;
    checks++; if (f_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL rst_ack_hold: got f%0h d%0h exp 0 0", f_ack, d_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_hold: got %0h exp 0", busy); end
    f_req = 1'b0; d_req = 1'b0; RST = 1'b0;
    step(); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL rst_rsp: got v%0h e%0h id%0h exp 0 0 0", rsp_valid, rsp_err, rsp_id); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin errors++; $display("FAIL rst_mem: got we%0h a%h wd%h exp 0", mem_we, mem_a, mem_wd); end
  endtask

  task automatic test_fetch();
    step(); f_req = 1'b1; f_addr = 32'h0; #1;
    checks++; if (f_ack !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack: got f%0h d%0h exp 1 0", f_ack, d_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy_T: got %0h exp 0", busy); end
    step(); f_req = 1'b0; #1;
    checks++; if (busy !== 1'b1 || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_access: got busy%0h we%0h v%0h exp 1 0 0", busy, mem_we, rsp_valid); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_rsp: got v%0h id%0h e%0h busy%0h exp 1 0 0 1", rsp_valid, rsp_id, rsp_err, busy); end
    checks++; if (rsp_rdata !== 32'h00500113) begin errors++; $display("FAIL fetch_rdata: got %h exp 00500113", rsp_rdata); end
    step(); #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle: got busy%0h v%0h exp 0 0", busy, rsp_valid); end
  endtask

  task automatic test_word_store_load();
    step(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; #1;
    checks++; if (d_ack !== 1'b1 || f_ack !== 1'b0) begin errors++; $display("FAIL wst_ack: got d%0h f%0h exp 1 0", d_ack, f_ack); end
    step(); d_req = 1'b0; #1;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'h10 || mem_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_access: got we%0h a%h wd%h exp 1 10 deadbeef", mem_we, mem_a, mem_wd); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wst_early_rsp: got %0h exp 0", rsp_valid); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_rdata !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL wst_rsp: got v%0h id%0h rd%h we%0h exp 1 1 0 0", rsp_valid, rsp_id, rsp_rdata, mem_we); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_mem: got %h exp deadbeef", mem[4]); end
    step(); d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0; #1;
    checks++; if (d_ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ld_ack: got ack%0h busy%0h exp 1 0", d_ack, busy); end
    step(); d_req = 1'b0; #1;
    checks++; if (mem_we !== 1'b0 || mem_a !== 32'h10) begin errors++; $display("FAIL ld_access: got we%0h a%h exp 0 10", mem_we, mem_a); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin errors++; $display("FAIL ld_rsp: got v%0h id%0h rd%h e%0h exp 1 1 deadbeef 0", rsp_valid, rsp_id, rsp_rdata, rsp_err); end
  endtask

  task automatic test_byte_store();
    step(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h22; d_wdata = 32'hFFFFFFAA; #1;
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL bst_ack: got %0h exp 1", d_ack); end
    step(); d_req = 1'b0; #1;
    checks++; if (mem_we !== 1'b0 || mem_a !== 32'h20 || busy !== 1'b1) begin errors++; $display("FAIL bst_access: got we%0h a%h busy%0h exp 0 20 1", mem_we, mem_a, busy); end
    step(); #1;
    checks++; if (mem_we !== 1'b1 || mem_a !== 32'h20 || mem_wd !== 32'h1122AA44 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bst_merge: got we%0h a%h wd%h v%0h exp 1 20 1122aa44 0", mem_we, mem_a, mem_wd, rsp_valid); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL bst_rsp: got v%0h rd%h e%0h we%0h exp 1 0 0 0", rsp_valid, rsp_rdata, rsp_err, mem_we); end
    checks++; if (mem[8] !== 32'h1122AA44) begin errors++; $display("FAIL bst_mem: got %h exp 1122aa44", mem[8]); end
    // Half store into the low half of 0x24
    step(); d_req = 1'b1; d_size = 2'b01; d_addr = 32'h26; d_wdata = 32'hABCD1234; #1;
    step(); d_req = 1'b0; step(); #1;
    checks++; if (mem_we !== 1'b1 || mem_wd !== 32'hCAFE1234) begin errors++; $display("FAIL hst_merge: got we%0h wd%h exp 1 cafe1234", mem_we, mem_wd); end
    step(); #1;
    // Byte store to offset 0 of 0x24
    step(); d_req = 1'b1; d_size = 2'b00; d_addr = 32'h24; d_wdata = 32'h0000005A; #1;
    step(); d_req = 1'b0; step(); #1;
    checks++; if (mem_wd !== 32'h5AFE1234) begin errors++; $display("FAIL bst0_merge: got %h exp 5afe1234", mem_wd); end
    step(); #1;
    checks++; if (mem[9] !== 32'h5AFE1234) begin errors++; $display("FAIL bst0_mem: got %h exp 5afe1234", mem[9]); end
  endtask

  task automatic test_misaligned();
    step(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h21; d_wdata = 32'h0000FFFF; #1;
    checks++; if (d_ack !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_half_ack: got ack%0h we%0h exp 1 0", d_ack, mem_we); end
    step(); d_req = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b1 || rsp_rdata !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_half_rsp: got v%0h e%0h id%0h rd%h we%0h exp 1 1 1 0 0", rsp_valid, rsp_err, rsp_id, rsp_rdata, mem_we); end
    step(); #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mis_half_idle: got busy%0h v%0h exp 0 0", busy, rsp_valid); end
    step(); d_req = 1'b1; d_size = 2'b11; d_addr = 32'h20; #1;
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL mis_sz11_ack: got %0h exp 1", d_ack); end
    step(); d_req = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL mis_sz11_rsp: got v%0h e%0h we%0h exp 1 1 0", rsp_valid, rsp_err, mem_we); end
    checks++; if (mem[8] !== 32'h1122AA44) begin errors++; $display("FAIL mis_mem: got %h exp 1122aa44", mem[8]); end
    step(); d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h12; #1;
    step(); d_req = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL mis_word_rsp: got v%0h e%0h exp 1 1", rsp_valid, rsp_err); end
    step(); f_req = 1'b1; f_addr = 32'h2; #1;
    checks++; if (f_ack !== 1'b1) begin errors++; $display("FAIL mis_fetch_ack: got %0h exp 1", f_ack); end
    step(); f_req = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL mis_fetch_rsp: got v%0h e%0h id%0h exp 1 1 0", rsp_valid, rsp_err, rsp_id); end
  endtask

  task automatic test_conflict();
    logic [3:0] exp_order;
    int n = 0;
    int cyc = 0;
    int prev = -1;
    logic last_who = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    step(); RST = 1'b1; step(); RST = 1'b0;
    step(); f_req = 1'b1; f_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h10;
    while (n < 4 && cyc < 40) begin
      #1;
      if (f_ack === 1'b1 || d_ack === 1'b1) begin
        checks++; if (d_ack !== exp_order[n] || f_ack !== ~exp_order[n]) begin errors++; $display("FAIL conflict_order%0d: got d%0h f%0h exp d%0h", n, d_ack, f_ack, exp_order[n]); end
        if (prev >= 0) begin
          checks++; if (cyc - prev != 3) begin errors++; $display("FAIL conflict_gap%0d: got %0d exp 3", n, cyc - prev); end
        end
        last_who = d_ack;
        prev = cyc;
        n++;
      end
      if (n < 4) begin step(); cyc++; end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL conflict_timeout: got %0d acks exp 4", n); end
    step(); f_req = 1'b0; d_req = 1'b0;
    step(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== last_who) begin errors++; $display("FAIL conflict_rsp: got v%0h id%0h exp 1 %0h", rsp_valid, rsp_id, last_who); end
    step();
  endtask

  task automatic test_reset_mid_store();
    mem[8] = 32'h11223344;
    step(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h22; d_wdata = 32'h000000AA; #1;
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL rms_ack: got %0h exp 1", d_ack); end
    step(); d_req = 1'b0;
    step(); RST = 1'b1; #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rms_we: got %0h exp 0", mem_we); end
    step(); RST = 1'b0; #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rms_idle: got busy%0h v%0h exp 0 0", busy, rsp_valid); end
    checks++; if (mem[8] !== 32'h11223344) begin errors++; $display("FAIL rms_mem: got %h exp 11223344", mem[8]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h00500113;
    mem[8] = 32'h11223344;
    mem[9] = 32'hCAFEF00D;
    RST = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b10;
    f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    step(); step();
    test_reset();
    test_fetch();
    test_word_store_load();
    test_byte_store();
    test_misaligned();
    test_conflict();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the unified instruction/data memory of the multicycle RISC-V core. It takes requests from the instruction-fetch port and the load/store port, and grants the single memory port to one requester at a time. It drives the memory's WE/A/WD, captures RD, and performs read-modify-write sequences for byte and halfword stores, because the memory only writes whole 32-bit words.

## Interface
- N, 32, address/data width
- CLK  in  1  clock; memory writes on rising edge, RD updates on falling edge
- RST  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held with f_addr until f_ack
- f_addr  in  N  fetch byte address
- f_ack  out  1  one-cycle pulse: fetch request accepted
- d_req  in  1  data request; held with d_* until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word (11 = illegal)
- d_addr  in  N  data byte address
- d_wdata  in  N  store data, right-justified (byte in [7:0], half in [15:0])
- d_ack  out  1  one-cycle pulse: data request accepted
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  0 = fetch, 1 = data
- rsp_rdata  out  N  raw aligned word read; 0 for stores
- rsp_err  out  1  misaligned or illegal-size request; no memory access performed
- mem_we  out  1  to memory WE
- mem_a  out  N  to memory A (always word-aligned)
- mem_wd  out  N  to memory WD
- mem_rd  in  N  from memory RD
- busy  out  1  high in any state other than IDLE

## Operation
- Memory is big-endian: byte offset 0 maps to bits [31:24] and offset 3 to [7:0].
- States and transitions:
  - IDLE -> ACCESS (accepted request)
  - IDLE -> RESP (error)
  - ACCESS -> RESP (load or word store)
  - ACCESS -> MERGE (byte/half store)
  - MERGE -> RESP
  - RESP -> IDLE
- IDLE:
  - if any request is pending, choose a winner, pulse its ack, and latch its fields;
  - loser keeps its request asserted and is reconsidered on the next IDLE cycle.
- Alignment check at acceptance:
  - half requires addr[0] = 0;
  - word requires addr[1:0] = 00;
  - fetch is always word; size 11 is illegal.
  - Failure goes to RESP with rsp_err = 1; mem_we stays 0.
- ACCESS:
  - mem_a = {addr[N-1:2], 2'b00};
  - word store: mem_we = 1, mem_wd = wdata;
  - otherwise mem_we = 0;
  - mem_rd is captured on the rising edge that ends ACCESS.
- MERGE:
  - mem_we = 1; mem_wd = the captured word with only the target lane replaced;
  - byte lane = bits [31-8*off -: 8];
  - half lane = [31:16] when off = 0, [15:0] when off = 2.
- RESP:
  - rsp_valid = 1 with rsp_id;
  - loads/fetches return the captured word, stores return 0;
  - rsp_err = 1 only for the rejected case.
- Default priority: data beats fetch.
- One transaction is in flight at a time. No new ack is issued while busy = 1.

## Timing
- Request accepted in cycle T: ack high during T (combinational from IDLE and req).
- Load, fetch, or word store: ACCESS at T+1, rsp_valid at T+2.
- Sub-word store: ACCESS at T+1, MERGE at T+2, rsp_valid at T+3.
- Error: rsp_valid at T+1.
- After a response, the earliest next ack is at T+3 (load) or T+4 (sub-word store), i.e. the first IDLE cycle.
- mem_we is gated by !RST, so no memory write occurs in any cycle where RST = 1. A sub-word store interrupted by reset in ACCESS or MERGE leaves memory unchanged.
- Reset values:
  - state IDLE;
  - f_ack, d_ack, rsp_valid, rsp_err, mem_we, busy = 0;
  - rsp_id = 0; rsp_rdata, mem_a, mem_wd = 0.
- Requests asserted while RST = 1 are not acked.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the requester not granted last wins.
  - The "last granted" pointer resets to fetch, so data wins the first conflict.
  - The pointer updates on every ack, including error acks.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. Fetch can starve while d_req stays high.

## Test plan
- Word store then load: d_we = 1, size 10, addr 0x10, wdata 0xDEADBEEF.
  - Expect mem_we high only in ACCESS and rsp at T+2.
  - Then a load of 0x10 returns rsp_rdata 0xDEADBEEF, rsp_id 1.
- Byte store: memory word at 0x20 = 0x11223344; store byte 0xAA to 0x22.
  - Expect a read in ACCESS, mem_wd 0x1122AA44 in MERGE, and rsp at T+3.
- Misaligned requests:
  - half store to 0x21 gives rsp_err = 1 at T+1, mem_we never high, memory unchanged;
  - size 11 gives the same result.
- Conflict: f_req and d_req both high for 4 consecutive transactions.
  - Without the macro: order D, D, D, D.
  - With MEM_ARB_RR_EN: order D, F, D, F.
  - The waiting port's inputs are held and its ack arrives only on the first IDLE cycle after the response.
- Reset mid-store: RST asserted during MERGE of a byte store to 0x20.
  - Expect mem_we = 0 that cycle, word 0x11223344 intact.
  - Next cycle: state IDLE, busy = 0, no rsp_valid.
- Fetch alone: f_req at 0x0 with memory preloaded 0x00500113.
  - Expect f_ack at T, rsp_valid/rsp_id 0/rdata 0x00500113 at T+2, busy high during T+1..T+2.
